// File: rtl/issueq_free_list.sv
// Circular free list of issue-queue entry indices: compacted allocation to the
// dispatch lanes, compacted reclamation from the issue lanes, registered occupancy.
module issueq_free_list #(
    parameter int DISPATCH_WIDTH  = 4,
    parameter int ISSUE_WIDTH     = 4,
    parameter int SIZE_ISSUEQ     = 32,
    parameter int SIZE_ISSUEQ_LOG = 5
) (
    input  logic                                            clk,
    input  logic                                            reset,
    input  logic                                            flush_i,
    input  logic                                            backEndReady_i,
    input  logic [DISPATCH_WIDTH-1:0]                       dispatchValid_i,
    output logic [DISPATCH_WIDTH-1:0][SIZE_ISSUEQ_LOG-1:0]  freeEntry_o,
    input  logic [ISSUE_WIDTH-1:0]                          freedValid_i,
    input  logic [ISSUE_WIDTH-1:0][SIZE_ISSUEQ_LOG-1:0]     freedEntry_i,
    output logic [SIZE_ISSUEQ_LOG:0]                        freeCnt_o,
    output logic [SIZE_ISSUEQ_LOG:0]                        issueQueueCnt_o,
    output logic                                            underflow_o,
    output logic                                            overflow_o
);

    localparam int CW = SIZE_ISSUEQ_LOG + 1;
    localparam logic [CW-1:0] SIZE_CNT = CW'(SIZE_ISSUEQ);
    localparam logic [CW:0]   SIZE_EXT = (CW + 1)'(SIZE_ISSUEQ);

    logic [SIZE_ISSUEQ_LOG-1:0] list [SIZE_ISSUEQ];
    logic [SIZE_ISSUEQ_LOG-1:0] headPtr;
    logic [SIZE_ISSUEQ_LOG-1:0] tailPtr;
    logic [CW-1:0]              freeCnt;
    logic [CW-1:0]              issueQueueCnt;
    logic                       underflow;
    logic                       overflow;

    logic [CW-1:0]              nAlloc;
    logic [CW-1:0]              nFree;
    logic [SIZE_ISSUEQ_LOG-1:0] allocOff [DISPATCH_WIDTH];
    logic [SIZE_ISSUEQ_LOG-1:0] freeOff  [ISSUE_WIDTH];
    logic [SIZE_ISSUEQ_LOG-1:0] readIdx  [DISPATCH_WIDTH];

    logic          allocReq;
    logic          allocCommit;
    logic          underflowEvt;
    logic          overflowEvt;
    logic [CW-1:0] nAllocCommitted;
    logic [CW-1:0] nFreeAccepted;
    logic [CW:0]   freeSum;
    logic [CW-1:0] freeCntNext;

    // Running prefix counts give each valid lane its compacted slot offset.
    // NOTE: blocking assignments here are intentional; the accumulator must be
    // read back within the same pass, and every output gets a default first.
    always_comb begin
        nAlloc = '0;
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            allocOff[i] = nAlloc[SIZE_ISSUEQ_LOG-1:0];
            nAlloc      = nAlloc + CW'(dispatchValid_i[i]);
        end
        nFree = '0;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            freeOff[i] = nFree[SIZE_ISSUEQ_LOG-1:0];
            nFree      = nFree + CW'(freedValid_i[i]);
        end
    end

    always_comb begin
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            readIdx[i]     = headPtr + allocOff[i];
            freeEntry_o[i] = list[readIdx[i]];
        end
    end

    // Alloc and free are both judged against the pre-edge count, so entries
    // freed this cycle can never rescue an allocation in the same cycle.
    always_comb begin
        allocReq        = backEndReady_i && !flush_i;
        allocCommit     = allocReq && (nAlloc <= freeCnt);
        underflowEvt    = allocReq && (nAlloc > freeCnt);
        nAllocCommitted = allocCommit ? nAlloc : '0;
        freeSum         = {1'b0, freeCnt} - {1'b0, nAllocCommitted} + {1'b0, nFree};
        overflowEvt     = !flush_i && (freeSum > SIZE_EXT);
        nFreeAccepted   = overflowEvt ? '0 : nFree;
        freeCntNext     = freeCnt - nAllocCommitted + nFreeAccepted;
    end

    // NOTE: the list array is reset deliberately; reset and flush must restore
    // the identity mapping list[i] = i, not merely rewind the pointers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SIZE_ISSUEQ; i++) list[i] <= SIZE_ISSUEQ_LOG'(i);
            headPtr       <= '0;
            tailPtr       <= '0;
            freeCnt       <= SIZE_CNT;
            issueQueueCnt <= '0;
            underflow     <= 1'b0;
            overflow      <= 1'b0;
        end else if (flush_i) begin
            for (int i = 0; i < SIZE_ISSUEQ; i++) list[i] <= SIZE_ISSUEQ_LOG'(i);
            headPtr       <= '0;
            tailPtr       <= '0;
            freeCnt       <= SIZE_CNT;
            issueQueueCnt <= '0;
        end else begin
            if (allocCommit) headPtr <= headPtr + nAlloc[SIZE_ISSUEQ_LOG-1:0];
            if (underflowEvt) underflow <= 1'b1;
            if (overflowEvt) begin
                overflow <= 1'b1;
            end else begin
                for (int i = 0; i < ISSUE_WIDTH; i++) begin
                    if (freedValid_i[i]) list[tailPtr + freeOff[i]] <= freedEntry_i[i];
                end
                tailPtr <= tailPtr + nFree[SIZE_ISSUEQ_LOG-1:0];
            end
            freeCnt       <= freeCntNext;
            issueQueueCnt <= SIZE_CNT - freeCntNext;
        end
    end

    assign freeCnt_o       = freeCnt;
    assign issueQueueCnt_o = issueQueueCnt;
    assign underflow_o     = underflow;
    assign overflow_o      = overflow;

endmodule

// File: tb/tb_issueq_free_list.sv
// Directed bench for issueq_free_list: each scenario task drives stimulus and
// compares outputs against hand-computed values.
module tb_issueq_free_list;

    localparam int DW  = 4;
    localparam int IW  = 4;
    localparam int SZ  = 32;
    localparam int LOG = 5;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    flush_i;
    logic                    backEndReady_i;
    logic [DW-1:0]           dispatchValid_i;
    logic [DW-1:0][LOG-1:0]  freeEntry_o;
    logic [IW-1:0]           freedValid_i;
    logic [IW-1:0][LOG-1:0]  freedEntry_i;
    logic [LOG:0]            freeCnt_o;
    logic [LOG:0]            issueQueueCnt_o;
    logic                    underflow_o;
    logic                    overflow_o;

    int nCompared   = 0;
    int nMismatched = 0;

    issueq_free_list #(
        .DISPATCH_WIDTH (DW),
        .ISSUE_WIDTH    (IW),
        .SIZE_ISSUEQ    (SZ),
        .SIZE_ISSUEQ_LOG(LOG)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .flush_i        (flush_i),
        .backEndReady_i (backEndReady_i),
        .dispatchValid_i(dispatchValid_i),
        .freeEntry_o    (freeEntry_o),
        .freedValid_i   (freedValid_i),
        .freedEntry_i   (freedEntry_i),
        .freeCnt_o      (freeCnt_o),
        .issueQueueCnt_o(issueQueueCnt_o),
        .underflow_o    (underflow_o),
        .overflow_o     (overflow_o)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; inputs change and outputs are sampled 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        flush_i         = 1'b0;
        backEndReady_i  = 1'b0;
        dispatchValid_i = '0;
        freedValid_i    = '0;
        freedEntry_i    = '0;
    endtask

    task automatic doReset();
        idleInputs();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic allocCycles(input int n, input logic [DW-1:0] mask);
        dispatchValid_i = mask;
        backEndReady_i  = 1'b1;
        repeat (n) step();
        dispatchValid_i = '0;
        backEndReady_i  = 1'b0;
    endtask

    task automatic test_reset();
        doReset();
        dispatchValid_i = 4'b1111;
        #1;
        for (int i = 0; i < DW; i++) begin
            nCompared++;
            if (freeEntry_o[i] !== LOG'(i)) begin
                nMismatched++;
                $display("FAIL reset_entry lane%0d: got %0d want %0d", i, freeEntry_o[i], i);
            end
        end
        nCompared++;
        if (freeCnt_o !== 6'd32) begin
            nMismatched++;
            $display("FAIL reset_freeCnt: got %0d want 32", freeCnt_o);
        end
        nCompared++;
        if (issueQueueCnt_o !== 6'd0 || underflow_o !== 1'b0 || overflow_o !== 1'b0) begin
            nMismatched++;
            $display("FAIL reset_iqcnt_flags: got cnt=%0d uf=%0b of=%0b want 0/0/0",
                     issueQueueCnt_o, underflow_o, overflow_o);
        end
        backEndReady_i = 1'b1;
        step();
        for (int i = 0; i < DW; i++) begin
            nCompared++;
            if (freeEntry_o[i] !== LOG'(4 + i)) begin
                nMismatched++;
                $display("FAIL first_commit_entry lane%0d: got %0d want %0d", i, freeEntry_o[i], 4 + i);
            end
        end
        nCompared++;
        if (issueQueueCnt_o !== 6'd4 || freeCnt_o !== 6'd28) begin
            nMismatched++;
            $display("FAIL first_commit_cnt: got iq=%0d free=%0d want 4/28", issueQueueCnt_o, freeCnt_o);
        end
        idleInputs();
    endtask

    task automatic test_sparse_mask();
        doReset();
        dispatchValid_i = 4'b1010;
        #1;
        nCompared++;
        if (freeEntry_o[1] !== 5'd0 || freeEntry_o[3] !== 5'd1) begin
            nMismatched++;
            $display("FAIL sparse_entry: got lane1=%0d lane3=%0d want 0/1", freeEntry_o[1], freeEntry_o[3]);
        end
        backEndReady_i = 1'b1;
        step();
        backEndReady_i  = 1'b0;
        dispatchValid_i = 4'b0001;
        #1;
        nCompared++;
        if (freeCnt_o !== 6'd30) begin
            nMismatched++;
            $display("FAIL sparse_freeCnt: got %0d want 30", freeCnt_o);
        end
        nCompared++;
        if (freeEntry_o[0] !== 5'd2) begin
            nMismatched++;
            $display("FAIL sparse_next_head: got %0d want 2", freeEntry_o[0]);
        end
        idleInputs();
    endtask

    task automatic test_fill_refill();
        doReset();
        allocCycles(8, 4'b1111);
        nCompared++;
        if (freeCnt_o !== 6'd0 || issueQueueCnt_o !== 6'd32) begin
            nMismatched++;
            $display("FAIL fill_cnt: got free=%0d iq=%0d want 0/32", freeCnt_o, issueQueueCnt_o);
        end
        freedValid_i    = 4'b0101;
        freedEntry_i[0] = 5'd5;
        freedEntry_i[2] = 5'd9;
        step();
        idleInputs();
        dispatchValid_i = 4'b1111;
        #1;
        nCompared++;
        if (freeCnt_o !== 6'd2) begin
            nMismatched++;
            $display("FAIL refill_freeCnt: got %0d want 2", freeCnt_o);
        end
        nCompared++;
        if (freeEntry_o[0] !== 5'd5 || freeEntry_o[1] !== 5'd9) begin
            nMismatched++;
            $display("FAIL refill_entry: got lane0=%0d lane1=%0d want 5/9", freeEntry_o[0], freeEntry_o[1]);
        end
        idleInputs();
    endtask

    task automatic test_simultaneous();
        doReset();
        allocCycles(5, 4'b1111);
        allocCycles(1, 4'b0011);
        nCompared++;
        if (freeCnt_o !== 6'd10) begin
            nMismatched++;
            $display("FAIL simul_setup_freeCnt: got %0d want 10", freeCnt_o);
        end
        dispatchValid_i = 4'b0011;
        backEndReady_i  = 1'b1;
        freedValid_i    = 4'b1011;
        freedEntry_i[0] = 5'd7;
        freedEntry_i[1] = 5'd3;
        freedEntry_i[3] = 5'd5;
        #1;
        nCompared++;
        if (freeEntry_o[0] !== 5'd22 || freeEntry_o[1] !== 5'd23) begin
            nMismatched++;
            $display("FAIL simul_entry: got lane0=%0d lane1=%0d want 22/23", freeEntry_o[0], freeEntry_o[1]);
        end
        step();
        idleInputs();
        nCompared++;
        if (freeCnt_o !== 6'd11 || issueQueueCnt_o !== 6'd21) begin
            nMismatched++;
            $display("FAIL simul_cnt: got free=%0d iq=%0d want 11/21", freeCnt_o, issueQueueCnt_o);
        end
    endtask

    task automatic test_flush();
        doReset();
        allocCycles(3, 4'b1111);
        flush_i         = 1'b1;
        dispatchValid_i = 4'b1111;
        backEndReady_i  = 1'b1;
        freedValid_i    = 4'b0011;
        freedEntry_i[0] = 5'd20;
        freedEntry_i[1] = 5'd21;
        step();
        idleInputs();
        dispatchValid_i = 4'b1111;
        #1;
        nCompared++;
        if (freeCnt_o !== 6'd32 || issueQueueCnt_o !== 6'd0) begin
            nMismatched++;
            $display("FAIL flush_cnt: got free=%0d iq=%0d want 32/0", freeCnt_o, issueQueueCnt_o);
        end
        for (int i = 0; i < DW; i++) begin
            nCompared++;
            if (freeEntry_o[i] !== LOG'(i)) begin
                nMismatched++;
                $display("FAIL flush_entry lane%0d: got %0d want %0d", i, freeEntry_o[i], i);
            end
        end
        nCompared++;
        if (underflow_o !== 1'b0 || overflow_o !== 1'b0) begin
            nMismatched++;
            $display("FAIL flush_flags: got uf=%0b of=%0b want 0/0", underflow_o, overflow_o);
        end
        idleInputs();
    endtask

    task automatic test_errors();
        doReset();
        allocCycles(7, 4'b1111);
        allocCycles(1, 4'b0111);
        dispatchValid_i = 4'b0011;
        backEndReady_i  = 1'b1;
        step();
        idleInputs();
        nCompared++;
        if (underflow_o !== 1'b1 || freeCnt_o !== 6'd1) begin
            nMismatched++;
            $display("FAIL underflow_set: got uf=%0b free=%0d want 1/1", underflow_o, freeCnt_o);
        end
        flush_i = 1'b1;
        step();
        idleInputs();
        nCompared++;
        if (underflow_o !== 1'b1 || freeCnt_o !== 6'd32) begin
            nMismatched++;
            $display("FAIL underflow_sticky_flush: got uf=%0b free=%0d want 1/32", underflow_o, freeCnt_o);
        end
        // Asynchronous reset between clock edges.
        allocCycles(1, 4'b1111);
        #2;
        reset = 1'b1;
        #1;
        nCompared++;
        if (underflow_o !== 1'b0 || freeCnt_o !== 6'd32 || issueQueueCnt_o !== 6'd0) begin
            nMismatched++;
            $display("FAIL async_reset: got uf=%0b free=%0d iq=%0d want 0/32/0",
                     underflow_o, freeCnt_o, issueQueueCnt_o);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        freedValid_i    = 4'b0001;
        freedEntry_i[0] = 5'd3;
        step();
        idleInputs();
        nCompared++;
        if (overflow_o !== 1'b1 || freeCnt_o !== 6'd32) begin
            nMismatched++;
            $display("FAIL overflow_set: got of=%0b free=%0d want 1/32", overflow_o, freeCnt_o);
        end
        // Empty list: same-cycle free cannot satisfy the allocation.
        doReset();
        allocCycles(8, 4'b1111);
        dispatchValid_i = 4'b0001;
        backEndReady_i  = 1'b1;
        freedValid_i    = 4'b0001;
        freedEntry_i[0] = 5'd4;
        step();
        idleInputs();
        dispatchValid_i = 4'b0001;
        #1;
        nCompared++;
        if (underflow_o !== 1'b1 || freeCnt_o !== 6'd1 || freeEntry_o[0] !== 5'd4) begin
            nMismatched++;
            $display("FAIL empty_alloc_free: got uf=%0b free=%0d lane0=%0d want 1/1/4",
                     underflow_o, freeCnt_o, freeEntry_o[0]);
        end
        idleInputs();
    endtask

    initial begin
        reset = 1'b1;
        idleInputs();
        #12;
        test_reset();
        test_sparse_mask();
        test_fill_refill();
        test_simultaneous();
        test_flush();
        test_errors();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/issueq_free_list.md
# issueq_free_list

Circular free list of Issue Queue entry indices, sitting directly downstream of the dispatch stage. Each cycle it offers up to `DISPATCH_WIDTH` free IQ slot indices to the dispatch lanes and reclaims up to `ISSUE_WIDTH` slots released by the issue/select logic. It also produces the registered IQ occupancy count that dispatch uses for its back-end-ready/stall decision.

## Interface
- `DISPATCH_WIDTH`, default 4: number of dispatch lanes.
- `ISSUE_WIDTH`, default 4: number of issue lanes that can free entries per cycle.
- `SIZE_ISSUEQ`, default 32: number of IQ entries. Must be a power of two.
- `SIZE_ISSUEQ_LOG`, default 5: log2(`SIZE_ISSUEQ`).

- `clk`, in, 1: the single clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `flush_i`, in, 1: recovery/exception flush (recoverFlag | exceptionFlag). Restores the all-free state.
- `backEndReady_i`, in, 1: dispatch commits this cycle's allocation.
- `dispatchValid_i`, in, `DISPATCH_WIDTH`: per-lane request for an IQ entry.
- `freeEntry_o`, out, `DISPATCH_WIDTH` x `SIZE_ISSUEQ_LOG`: IQ index assigned to each lane.
- `freedValid_i`, in, `ISSUE_WIDTH`: per-lane "entry released" strobe.
- `freedEntry_i`, in, `ISSUE_WIDTH` x `SIZE_ISSUEQ_LOG`: released IQ index.
- `freeCnt_o`, out, `SIZE_ISSUEQ_LOG`+1: number of free entries (registered).
- `issueQueueCnt_o`, out, `SIZE_ISSUEQ_LOG`+1: occupied entries, equal to `SIZE_ISSUEQ` − `freeCnt_o` (registered).
- `underflow_o`, out, 1: sticky error, set when an allocation exceeds the free count.
- `overflow_o`, out, 1: sticky error, set when frees would push the free count above `SIZE_ISSUEQ`.

## Operation

**Storage and pointers**
- `SIZE_ISSUEQ` x `SIZE_ISSUEQ_LOG` list array.
- `headPtr` and `tailPtr` are `SIZE_ISSUEQ_LOG` bits wide and wrap modulo `SIZE_ISSUEQ`.
- `freeCnt` is `SIZE_ISSUEQ_LOG`+1 bits wide.

**Reset and flush**
- Both set `list[i]=i`, `headPtr=0`, `tailPtr=0`, `freeCnt=SIZE_ISSUEQ`.
- Both clear the pending allocation and ignore same-cycle frees.
- The sticky error flags are cleared by `reset` only. `flush_i` does not clear them.

**Allocation (compacted)**
- Let k(i) be the number of set bits of `dispatchValid_i` below lane i.
- `freeEntry_o[i] = list[headPtr + k(i)]`. This is driven for every lane, including invalid ones, and is don't-care for invalid lanes.
- `nAlloc = popcount(dispatchValid_i)`.
- The allocation commits when `backEndReady_i && !flush_i && nAlloc <= freeCnt`. On commit, `headPtr += nAlloc`.
- If `backEndReady_i && !flush_i && nAlloc > freeCnt`: no commit, and `underflow_o` is set.

**Free (compacted)**
- Valid freed indices are written at `tailPtr`, `tailPtr+1`, … in ascending lane order.
- `nFree = popcount(freedValid_i)`. On write, `tailPtr += nFree`.
- If `freeCnt − nAllocCommitted + nFree > SIZE_ISSUEQ`: the frees are dropped and `overflow_o` is set.

**Count update**
- `freeCnt_next = freeCnt − nAllocCommitted + nFreeAccepted`.
- Alloc and free may occur in the same cycle. Both are evaluated against the pre-edge state.
- Entries freed in cycle N are not visible to allocation before cycle N+1. This holds even when `freeCnt` is 0 before the edge.

**Other**
- Indices are not checked for duplicates. Dispatch/issue guarantee uniqueness.

## Timing
- `freeEntry_o`: combinational from `headPtr` and `dispatchValid_i`. Zero-cycle latency, valid in the same cycle as the request.
- `headPtr`, `tailPtr`, `freeCnt`, the list array and the error flags update on the rising edge of `clk`.
- `freeCnt_o` and `issueQueueCnt_o` reflect a cycle's alloc/free one cycle later.
- Reset values:
  - `freeCnt_o=SIZE_ISSUEQ`, `issueQueueCnt_o=0`.
  - `underflow_o=0`, `overflow_o=0`.
  - `freeEntry_o[i]` equals the number of valid lanes below i (i.e. the indices 0, 1, …).
- `reset` asserted mid-operation returns all state to the reset values immediately (asynchronously), regardless of the clock.
- `flush_i` has priority over alloc and free in the same cycle.
- `freeCnt=0` with `nAlloc>0` is an underflow. Dispatch must drop `backEndReady_i` via `issueQueueCnt_o` beforehand.

## Test plan
- **Reset:** release reset, `dispatchValid_i=4'b1111` → `freeEntry_o={0,1,2,3}`, `freeCnt_o=32`, `issueQueueCnt_o=0`. Commit → next cycle `freeEntry_o={4,5,6,7}`, `issueQueueCnt_o=4`.
- **Sparse mask:** from the post-reset state, `dispatchValid_i=4'b1010` → lane1=0, lane3=1. Commit → `freeCnt_o=30`, next head index 2.
- **Fill and refill:** allocate 32 over 8 full cycles → `freeCnt_o=0`, `issueQueueCnt_o=32`. Free entries 5 and 9 on issue lanes 0 and 2 → next cycle `freeCnt_o=2`, `freeEntry_o` lane0=5, lane1=9.
- **Simultaneous events:** with `freeCnt=10`, allocate 2 and free 3 in the same cycle → `freeCnt_o=11`. The freed indices are not handed out in that cycle.
- **Flush:** after 12 allocations, assert `flush_i` together with a 4-lane alloc and 2 frees → next cycle `freeCnt_o=32`, `freeEntry_o={0,1,2,3}`, both error flags 0.
- **Errors:** with `freeCnt=1`, commit a 2-lane alloc → `underflow_o=1`, `freeCnt_o` stays 1. Then apply `flush_i` → `underflow_o` remains 1. Then apply `reset` → `underflow_o=0`.
